tank_level_model: RTL and testbench

TANK_LEVEL_MODEL -- requirements
Module: tank_level_model

---
 rtl/tank_level_model_pkg.sv | 19 +
 rtl/tank_level_model_if.sv | 27 ++
 rtl/tank_level_model_sat_counter16.sv | 17 +
 rtl/tank_level_model.sv | 131 +++++++++++++
 tb/tb_tank_level_model.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/tank_level_model_pkg.sv
// Shared definitions for the tank level model: zone encoding and default thresholds.
package tank_level_model_pkg;

  typedef enum logic [1:0] {
    ZONE_DRY  = 2'd0,
    ZONE_LOW  = 2'd1,
    ZONE_MID  = 2'd2,
    ZONE_HIGH = 2'd3
  } zone_e;

  localparam int LVL_W_DEF      = 8;
  localparam int PUMP_RATE_DEF  = 4;
  localparam int I_ON_DEF       = 64;
  localparam int I_OFF_DEF      = 48;
  localparam int S_ON_DEF       = 192;
  localparam int S_OFF_DEF      = 176;
  localparam int DRY_CYCLES_DEF = 3;

endpackage

// File: rtl/tank_level_model_if.sv
// Pump commands, inflow and observed tank state between controller side and plant model.
interface tank_level_model_if #(
  parameter int LVL_W = 8
);

  logic             B1;
  logic             B2;
  logic [3:0]       in_rate;
  logic             I;
  logic             S;
  logic [LVL_W-1:0] level;
  logic             dry_fault;
  logic             overflow;
  logic [15:0]      run1;
  logic [15:0]      run2;

  modport master (
    output B1, B2, in_rate,
    input  I, S, level, dry_fault, overflow, run1, run2
  );

  modport slave (
    input  B1, B2, in_rate,
    output I, S, level, dry_fault, overflow, run1, run2
  );

endinterface

// File: rtl/tank_level_model_sat_counter16.sv
// 16-bit up counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/tank_level_model.sv
// Behavioural tank plant: integrates inflow minus pump drain, derives level-sensor
// zones with hysteresis, and tracks dry-run / overflow faults and pump run time.
module tank_level_model
  import tank_level_model_pkg::*;
#(
  parameter int LVL_W      = LVL_W_DEF,
  parameter int PUMP_RATE  = PUMP_RATE_DEF,
  parameter int I_ON       = I_ON_DEF,
  parameter int I_OFF      = I_OFF_DEF,
  parameter int S_ON       = S_ON_DEF,
  parameter int S_OFF      = S_OFF_DEF,
  parameter int DRY_CYCLES = DRY_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             R,
  tank_level_model_if.slave bus
);

  // Three guard bits cover the 4-bit inflow and a double-pump drain going negative.
  localparam int NW    = LVL_W + 3;
  localparam int DRY_W = (DRY_CYCLES < 2) ? 1 : $clog2(DRY_CYCLES + 1);

  localparam logic signed [NW-1:0] LVL_MAX  = NW'((2 ** LVL_W) - 1);
  localparam logic [LVL_W-1:0]     I_ON_L   = LVL_W'(I_ON);
  localparam logic [LVL_W-1:0]     I_OFF_L  = LVL_W'(I_OFF);
  localparam logic [LVL_W-1:0]     S_ON_L   = LVL_W'(S_ON);
  localparam logic [LVL_W-1:0]     S_OFF_L  = LVL_W'(S_OFF);
  localparam logic [DRY_W-1:0]     DRY_MAX  = DRY_W'(DRY_CYCLES);
  localparam logic [DRY_W-1:0]     DRY_LAST = DRY_W'(DRY_CYCLES - 1);

  function automatic logic signed [NW-1:0] net_level(
    input logic [LVL_W-1:0] lvl,
    input logic [3:0]       rate,
    input logic             p1,
    input logic             p2
  );
    logic signed [NW-1:0] drain;
    drain = '0;
    if (p1) drain = drain + NW'(PUMP_RATE);
    if (p2) drain = drain + NW'(PUMP_RATE);
    return $signed(NW'(lvl)) + $signed(NW'(rate)) - drain;
  endfunction

  function automatic logic [LVL_W-1:0] clamp_level(input logic signed [NW-1:0] v);
    if (v < 0)       return '0;
    if (v > LVL_MAX) return '1;
    return v[LVL_W-1:0];
  endfunction

  logic signed [NW-1:0] next_raw;
  logic [LVL_W-1:0]     next_lvl;
  logic [LVL_W-1:0]     level_q;
  zone_e                zone_q;
  zone_e                zone_d;
  logic [DRY_W-1:0]     dry_cnt;
  logic                 dry_now;
  logic                 dry_fault_q;
  logic                 overflow_q;

  assign next_raw = net_level(level_q, bus.in_rate, bus.B1, bus.B2);
  assign next_lvl = clamp_level(next_raw);
  assign dry_now  = (level_q == '0) && (bus.B1 || bus.B2);

  // Zone follows the clamped next level so it never lags the level register.
  always_comb begin
    zone_d = zone_q;
    if (next_lvl == '0) begin
      zone_d = ZONE_DRY;
    end else if (next_lvl >= S_ON_L) begin
      zone_d = ZONE_HIGH;
    end else begin
      case (zone_q)
        ZONE_DRY, ZONE_LOW: zone_d = (next_lvl >= I_ON_L) ? ZONE_MID : ZONE_LOW;
        ZONE_MID:           zone_d = (next_lvl < I_OFF_L) ? ZONE_LOW : ZONE_MID;
        ZONE_HIGH: begin
          if (next_lvl >= S_OFF_L)      zone_d = ZONE_HIGH;
          else if (next_lvl >= I_OFF_L) zone_d = ZONE_MID;
          else                          zone_d = ZONE_LOW;
        end
        default:            zone_d = ZONE_DRY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      zone_q <= ZONE_DRY;
    end else begin
      zone_q <= zone_d;
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      level_q     <= '0;
      dry_cnt     <= '0;
      dry_fault_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      level_q <= next_lvl;
      if (dry_now) begin
        if (dry_cnt != DRY_MAX) dry_cnt <= dry_cnt + 1'b1;
        if (dry_cnt == DRY_LAST) dry_fault_q <= 1'b1;
      end else begin
        dry_cnt <= '0;
      end
      if (next_raw > LVL_MAX) overflow_q <= 1'b1;
    end
  end

  assign bus.level     = level_q;
  assign bus.I         = (zone_q == ZONE_MID) || (zone_q == ZONE_HIGH);
  assign bus.S         = (zone_q == ZONE_HIGH);
  assign bus.dry_fault = dry_fault_q;
  assign bus.overflow  = overflow_q;

  sat_counter16 u_run1 (
    .clk   (clk),
    .rst   (R),
    .en    (bus.B1),
    .count (bus.run1)
  );

  sat_counter16 u_run2 (
    .clk   (clk),
    .rst   (R),
    .en    (bus.B2),
    .count (bus.run2)
  );

endmodule

// File: tb/tb_tank_level_model.sv
// Scoreboard bench for tank_level_model: directed fill/drain/dry/overflow/reset sequences.
module tb_tank_level_model;

  logic clk = 1'b0;
  logic R;

  always #5 clk = ~clk;

  tank_level_model_if #(.LVL_W(8)) bus ();

  tank_level_model #(
    .LVL_W      (8),
    .PUMP_RATE  (4),
    .I_ON       (64),
    .I_OFF      (48),
    .S_ON       (192),
    .S_OFF      (176),
    .DRY_CYCLES (3)
  ) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [7:0]  level;
    logic        i;
    logic        s;
    logic        df;
    logic        ov;
    logic [15:0] r1;
    logic [15:0] r2;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   er1, er2;
  logic edf, eov;
  event obs;

  always @(negedge clk) -> obs;

  task automatic chk1(input string n, input string f, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
    end
  endtask

  // Monitor: compares one queued expectation per observation point.
  initial begin
    exp_t e;
    forever begin
      @(obs);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1(e.name, "level",     16'(bus.level),     16'(e.level));
        chk1(e.name, "I",         16'(bus.I),         16'(e.i));
        chk1(e.name, "S",         16'(bus.S),         16'(e.s));
        chk1(e.name, "dry_fault", 16'(bus.dry_fault), 16'(e.df));
        chk1(e.name, "overflow",  16'(bus.overflow),  16'(e.ov));
        chk1(e.name, "run1",      bus.run1,           e.r1);
        chk1(e.name, "run2",      bus.run2,           e.r2);
      end
    end
  end

  task automatic expect_now(input string n, input logic [7:0] lvl, input logic i, input logic s);
    exp_t e;
    e.name  = n;
    e.level = lvl;
    e.i     = i;
    e.s     = s;
    e.df    = edf;
    e.ov    = eov;
    e.r1    = 16'(er1);
    e.r2    = 16'(er2);
    sb.push_back(e);
  endtask

  task automatic step(input logic b1, input logic b2, input logic [3:0] rate,
                      input string n, input logic [7:0] lvl, input logic i, input logic s);
    bus.B1      = b1;
    bus.B2      = b2;
    bus.in_rate = rate;
    @(posedge clk);
    #1;
    if (b1) er1++;
    if (b2) er2++;
    expect_now(n, lvl, i, s);
  endtask

  // Reset asserted between clock edges and checked before any edge can occur.
  task automatic do_reset(input string n);
    @(negedge clk);
    #1 R = 1'b1;
    er1 = 0;
    er2 = 0;
    edf = 1'b0;
    eov = 1'b0;
    #1;
    expect_now(n, 8'd0, 1'b0, 1'b0);
    -> obs;
    #1 R = 1'b0;
  endtask

  initial begin
    R           = 1'b1;
    bus.B1      = 1'b0;
    bus.B2      = 1'b0;
    bus.in_rate = 4'd0;
    er1 = 0;
    er2 = 0;
    edf = 1'b0;
    eov = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    for (int k = 1; k <= 24; k++)
      step(1'b0, 1'b0, 4'd8, "fill", 8'(8 * k), k >= 8, k >= 24);

    for (int k = 1; k <= 24; k++) begin
      int lv;
      lv = 192 - 8 * k;
      step(1'b1, 1'b1, 4'd0, "drain", 8'(lv), lv >= 48, lv >= 176);
    end

    do_reset("dry_reset");
    step(1'b1, 1'b0, 4'd0, "dry1", 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, "dry2", 8'd0, 1'b0, 1'b0);
    edf = 1'b1;
    step(1'b1, 1'b0, 4'd0, "dry3", 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, "dry_hold", 8'd0, 1'b0, 1'b0);

    do_reset("ovf_reset");
    for (int k = 1; k <= 25; k++)
      step(1'b0, 1'b0, 4'd10, "ovf_fill", 8'(10 * k), (10 * k) >= 64, (10 * k) >= 192);
    eov = 1'b1;
    step(1'b0, 1'b0, 4'd15, "ovf", 8'd255, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'd0, "ovf_hold", 8'd255, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'd0, "ovf_drain", 8'd251, 1'b1, 1'b1);

    do_reset("pre_mid");
    for (int k = 1; k <= 10; k++)
      step(1'b0, 1'b0, 4'd10, "mid_fill", 8'(10 * k), (10 * k) >= 64, 1'b0);
    do_reset("mid_reset");
    for (int k = 1; k <= 8; k++)
      step(1'b0, 1'b0, 4'd8, "refill", 8'(8 * k), k >= 8, 1'b0);

    for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_queue: %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
